// File: rtl/cpu_core_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core_if
// Purpose  : Instruction- and data-memory req/ack bus seen from the cpu_core.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_core_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8
);
  logic                       o_imem_req;
  logic [INST_ADDR_WIDTH-1:0] o_imem_addr;
  logic                       i_imem_ack;
  logic [15:0]                i_imem_data;
  logic                       o_dmem_req;
  logic                       o_dmem_we;
  logic [DATA_ADDR_WIDTH-1:0] o_dmem_addr;
  logic [DATA_WIDTH-1:0]      o_dmem_wdata;
  logic                       i_dmem_ack;
  logic [DATA_WIDTH-1:0]      i_dmem_rdata;

  modport master (
    output o_imem_req, o_imem_addr, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
    input  i_imem_ack, i_imem_data, i_dmem_ack, i_dmem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
    output i_imem_ack, i_imem_data, i_dmem_ack, i_dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module   : cpu_core
// Purpose  : Multi-cycle 4-register CPU (IDLE/FETCH/EXEC/MEM/HALT) with
//            req/ack memories. CPU_CORE_RETIRE_CNT_EN builds the retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_core #(
  parameter int DATA_WIDTH      = 16,
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  cpu_core_if.master                 bus,
  input  logic [1:0]                 i_dbg_sel,
  output logic [DATA_WIDTH-1:0]      o_dbg_data,
  output logic [INST_ADDR_WIDTH-1:0] o_pc,
  output logic                       o_halted,
  output logic [31:0]                o_retired,
  output logic [2:0]                 o_leds
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_AND   = 4'd2;
  localparam logic [3:0] c_OP_OR    = 4'd3;
  localparam logic [3:0] c_OP_SHIFT = 4'd4;
  localparam logic [3:0] c_OP_LOAD  = 4'd5;
  localparam logic [3:0] c_OP_STORE = 4'd6;
  localparam logic [3:0] c_OP_MOVE  = 4'd7;
  localparam logic [3:0] c_OP_JUMP  = 4'd8;
  localparam logic [3:0] c_OP_LOADC = 4'd9;
  localparam logic [3:0] c_OP_HALT  = 4'd15;

  state_t                     r_state, w_next_state;
  logic [INST_ADDR_WIDTH-1:0] r_pc;
  logic [15:0]                r_inst;
  logic [DATA_WIDTH-1:0]      r_regs [4];
  logic                       r_dmem_we;
  logic [DATA_ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0]      r_dmem_wdata;
  logic                       r_halted;

  logic [3:0]                 w_op;
  logic [1:0]                 w_rd, w_x;
  logic [4:0]                 w_shamt;
  logic [DATA_WIDTH-1:0]      w_k, w_rd_val, w_b, w_result;
  logic                       w_wr_en, w_jump, w_is_mem, w_is_halt;
  logic [INST_ADDR_WIDTH-1:0] w_pc_inc, w_next_pc;

  assign w_op      = r_inst[15:12];
  assign w_rd      = r_inst[11:10];
  assign w_x       = r_inst[9:8];
  assign w_shamt   = r_inst[4:0];
  assign w_k       = DATA_WIDTH'(r_inst[7:0]);
  assign w_rd_val  = r_regs[w_rd];
  assign w_b       = w_x[1] ? w_k : r_regs[r_inst[1:0]];
  assign w_is_mem  = (w_op == c_OP_LOAD) || (w_op == c_OP_STORE);
  assign w_is_halt = (w_op == c_OP_HALT);
  assign w_pc_inc  = r_pc + INST_ADDR_WIDTH'(1);
  assign w_next_pc = w_jump ? INST_ADDR_WIDTH'(r_inst[7:0]) : w_pc_inc;

  always_comb begin
    w_result = w_rd_val;
    w_wr_en  = 1'b0;
    w_jump   = 1'b0;
    case (w_op)
      c_OP_ADD:   begin w_result = w_rd_val + w_b; w_wr_en = 1'b1; end
      c_OP_SUB:   begin w_result = w_rd_val - w_b; w_wr_en = 1'b1; end
      c_OP_AND:   begin w_result = w_rd_val & w_b; w_wr_en = 1'b1; end
      c_OP_OR:    begin w_result = w_rd_val | w_b; w_wr_en = 1'b1; end
      c_OP_SHIFT: begin
        w_wr_en = 1'b1;
        if (32'(w_shamt) >= 32'(DATA_WIDTH)) w_result = '0;
        else if (w_x[0])                     w_result = w_rd_val >> w_shamt;
        else                                 w_result = w_rd_val << w_shamt;
      end
      c_OP_MOVE:  begin w_result = r_regs[w_x]; w_wr_en = 1'b1; end
      c_OP_LOADC: begin w_result = w_k; w_wr_en = 1'b1; end
      c_OP_JUMP: begin
        case (w_x)
          2'b00:   w_jump = 1'b1;
          2'b01:   w_jump = (w_rd_val == '0);
          2'b10:   w_jump = (w_rd_val != '0);
          default: w_jump = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: if (bus.i_imem_ack) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_is_mem)       w_next_state = S_MEM;
        else if (w_is_halt) w_next_state = S_HALT;
        else                w_next_state = S_FETCH;
      end
      S_MEM:   if (bus.i_dmem_ack) w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= '0;
      r_inst       <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_halted     <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (bus.i_imem_ack) r_inst <= bus.i_imem_data;
        S_EXEC: begin
          if (w_wr_en) r_regs[w_rd] <= w_result;
          if (w_is_mem) begin
            r_dmem_we    <= (w_op == c_OP_STORE);
            r_dmem_addr  <= DATA_ADDR_WIDTH'(r_inst[7:0]);
            r_dmem_wdata <= w_rd_val;
          end else if (w_is_halt) begin
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        S_MEM: if (bus.i_dmem_ack) begin
          if (!r_dmem_we) r_regs[w_rd] <= bus.i_dmem_rdata;
          r_dmem_we <= 1'b0;
          r_pc      <= w_pc_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_CORE_RETIRE_CNT_EN
  logic [31:0] r_retired;
  logic        w_retire;
  // Non-memory ops (including HALT) complete in EXEC; memory ops on their ack.
  assign w_retire = ((r_state == S_EXEC) && !w_is_mem) ||
                    ((r_state == S_MEM) && bus.i_dmem_ack);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end
  assign o_retired = r_retired;
`else
  assign o_retired = 32'd0;
`endif

  assign bus.o_imem_req   = (r_state == S_FETCH);
  assign bus.o_imem_addr  = r_pc;
  assign bus.o_dmem_req   = (r_state == S_MEM);
  assign bus.o_dmem_we    = r_dmem_we;
  assign bus.o_dmem_addr  = r_dmem_addr;
  assign bus.o_dmem_wdata = r_dmem_wdata;
  assign o_dbg_data       = r_regs[i_dbg_sel];
  assign o_pc             = r_pc;
  assign o_halted         = r_halted;
  assign o_leds           = r_regs[0][2:0];

endmodule
`default_nettype wire
